// File: rtl/clock_pkg.sv
// Shared constants for the digital-clock design: 50 MHz cycle counts for
// push-button timing and the index of each DE2 key in the key bus.
package clock_pkg;

   localparam int DEBOUNCE_20MS = 1_000_000;
   localparam int LONG_1S       = 50_000_000;
   localparam int REPEAT_200MS  = 10_000_000;

   localparam int KEY_ADD = 0;
   localparam int KEY_CLR = 1;
   localparam int KEY_ADJ = 2;
   localparam int KEY_SEL = 3;

endpackage

// File: rtl/key_debounce_ch.sv
// One push-button channel: synchroniser, stable-time debounce, and the
// press/release/long/repeat event generators built on the debounced level.
module key_debounce_ch
   import clock_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS,
   parameter int LONG_CYCLES     = LONG_1S,
   parameter int REPEAT_CYCLES   = REPEAT_200MS
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic key_level,
   output logic key_press,
   output logic key_release,
   output logic key_long,
   output logic key_repeat
);

   localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
   localparam int REP_W  = $clog2(REPEAT_CYCLES + 1);

   localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);
   localparam logic [REP_W-1:0]  REP_LAST = REP_W'(REPEAT_CYCLES - 1);

   logic              sync_q;
   logic              raw_p;
   logic [DEB_W-1:0]  deb_cnt;
   logic [HOLD_W-1:0] hold_cnt;
   logic [REP_W-1:0]  rep_cnt;

   logic differ;
   logic accept;
   logic level_next;
   logic hold_full;
   logic long_due;
   logic repeat_due;

   // A level change is accepted only once the counter has seen the full
   // stable window; long/repeat are suppressed on the edge that releases.
   always_comb begin
      differ     = (raw_p != key_level);
      accept     = differ && (deb_cnt == DEB_LAST);
      level_next = accept ? raw_p : key_level;
      hold_full  = (hold_cnt == HOLD_MAX);
      long_due   = key_level && level_next && (hold_cnt == HOLD_PRE);
      repeat_due = key_level && level_next && hold_full && (rep_cnt == REP_LAST);
   end

   // Two-stage synchroniser on the inverted button so raw_p is 1 when pressed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 1'b0;
         raw_p  <= 1'b0;
      end else begin
         sync_q <= ~key_n;
         raw_p  <= sync_q;
      end
   end

   // Debounce counter restarts from zero on any glitch back to the current level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb_cnt     <= '0;
         key_level   <= 1'b0;
         key_press   <= 1'b0;
         key_release <= 1'b0;
      end else begin
         key_press   <= accept && raw_p;
         key_release <= accept && !raw_p;
         key_level   <= level_next;
         if (!differ || accept)
            deb_cnt <= '0;
         else
            deb_cnt <= deb_cnt + 1'b1;
      end
   end

   // Hold count saturates at the long-press point; the repeat counter then
   // runs freely and wraps once per repeat period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt   <= '0;
         rep_cnt    <= '0;
         key_long   <= 1'b0;
         key_repeat <= 1'b0;
      end else begin
         key_long   <= long_due;
         key_repeat <= repeat_due;
         if (!key_level)
            hold_cnt <= '0;
         else if (!hold_full)
            hold_cnt <= hold_cnt + 1'b1;
         if (!key_level || !hold_full || (rep_cnt == REP_LAST))
            rep_cnt <= '0;
         else
            rep_cnt <= rep_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/key_debounce.sv
// Conditions the DE2 push-buttons: one independent debounce channel per key.
module key_debounce
   import clock_pkg::*;
#(
   parameter int N_KEYS          = 4,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS,
   parameter int LONG_CYCLES     = LONG_1S,
   parameter int REPEAT_CYCLES   = REPEAT_200MS
) (
   input  logic              CLOCK_50,
   input  logic              rst_n,
   input  logic [N_KEYS-1:0] KEY,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release,
   output logic [N_KEYS-1:0] key_long,
   output logic [N_KEYS-1:0] key_repeat
);

   for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
      key_debounce_ch #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .LONG_CYCLES    (LONG_CYCLES),
         .REPEAT_CYCLES  (REPEAT_CYCLES)
      ) u_ch (
         .clk        (CLOCK_50),
         .rst_n      (rst_n),
         .key_n      (KEY[i]),
         .key_level  (key_level[i]),
         .key_press  (key_press[i]),
         .key_release(key_release[i]),
         .key_long   (key_long[i]),
         .key_repeat (key_repeat[i])
      );
   end

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce with short timing constants; expected
// events are queued by the stimulus and matched by an independent monitor.
module tb_key_debounce;

   localparam int N    = 4;
   localparam int DEB  = 8;
   localparam int LONG = 40;
   localparam int REP  = 10;
   localparam int LAT  = 2 + DEB;

   typedef enum int {EV_PRESS = 0, EV_RELEASE = 1, EV_LONG = 2, EV_REPEAT = 3} ev_kind_t;
   typedef struct {
      int       cycle;
      ev_kind_t kind;
      int       key;
   } ev_t;

   logic         CLOCK_50 = 1'b0;
   logic         rst_n    = 1'b0;
   logic [N-1:0] KEY      = '1;
   logic [N-1:0] key_level, key_press, key_release, key_long, key_repeat;

   ev_t expq[$];
   int  cyc        = 0;
   int  assert_cnt = 0;
   int  fail_cnt   = 0;

   key_debounce #(
      .N_KEYS(N), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP)
   ) dut (
      .CLOCK_50   (CLOCK_50),
      .rst_n      (rst_n),
      .KEY        (KEY),
      .key_level  (key_level),
      .key_press  (key_press),
      .key_release(key_release),
      .key_long   (key_long),
      .key_repeat (key_repeat)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   always @(posedge CLOCK_50) cyc <= cyc + 1;

   function automatic string kindName(int t);
      case (t)
         0:       return "press";
         1:       return "release";
         2:       return "long";
         default: return "repeat";
      endcase
   endfunction

   task automatic expectEvent(int cycle, ev_kind_t kind, int key);
      ev_t e;
      e.cycle = cycle;
      e.kind  = kind;
      e.key   = key;
      expq.push_back(e);
   endtask

   task automatic tick(int n);
      repeat (n) @(negedge CLOCK_50);
   endtask

   task automatic applyStimulus(int key, logic value);
      KEY[key] = value;
   endtask

   task automatic checkOutput(string name, logic [N-1:0] actual, logic [N-1:0] expected);
      assert_cnt++;
      if (actual !== expected) begin
         fail_cnt++;
         $display("[TB] FAIL %s: got %b, expected %b (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Monitor: every observed pulse must match a queued expectation for this
   // cycle; any expectation whose cycle has passed was missed.
   always @(negedge CLOCK_50) begin : monitor
      logic [N-1:0] vec;
      int           idx;
      for (int t = 0; t < 4; t++) begin
         case (t)
            0:       vec = key_press;
            1:       vec = key_release;
            2:       vec = key_long;
            default: vec = key_repeat;
         endcase
         for (int k = 0; k < N; k++) begin
            if (vec[k]) begin
               idx = -1;
               for (int i = 0; i < expq.size(); i++)
                  if (idx < 0 && expq[i].cycle == cyc && int'(expq[i].kind) == t && expq[i].key == k)
                     idx = i;
               assert_cnt++;
               if (idx < 0) begin
                  fail_cnt++;
                  $display("[TB] FAIL unexpected %s key%0d: pulse seen at cycle %0d, none required",
                           kindName(t), k, cyc);
               end else begin
                  expq.delete(idx);
               end
            end
         end
      end
      for (int i = expq.size() - 1; i >= 0; i--) begin
         if (expq[i].cycle < cyc) begin
            assert_cnt++;
            fail_cnt++;
            $display("[TB] FAIL missing %s key%0d: no pulse seen, required at cycle %0d",
                     kindName(int'(expq[i].kind)), expq[i].key, expq[i].cycle);
            expq.delete(i);
         end
      end
   end

   initial begin
      int c, p, d;

      // Reset state
      tick(3);
      checkOutput("reset level",   key_level,   '0);
      checkOutput("reset press",   key_press,   '0);
      checkOutput("reset release", key_release, '0);
      checkOutput("reset long",    key_long,    '0);
      checkOutput("reset repeat",  key_repeat,  '0);
      rst_n = 1'b1;
      tick(3);

      // Clean press and quick release on key 0
      $display("[TB] clean press");
      c = cyc;
      applyStimulus(0, 1'b0);
      expectEvent(c + LAT, EV_PRESS, 0);
      tick(LAT - 1);
      checkOutput("level before accept", key_level, 4'b0000);
      tick(1);
      checkOutput("level after press", key_level, 4'b0001);
      c = cyc;
      applyStimulus(0, 1'b1);
      expectEvent(c + LAT, EV_RELEASE, 0);
      tick(LAT + 2);
      checkOutput("level after release", key_level, 4'b0000);

      // Bounce rejection on key 1
      $display("[TB] bounce rejection");
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1, (i % 2 == 0) ? 1'b0 : 1'b1);
         tick(3);
      end
      checkOutput("level during bounce", key_level, 4'b0000);
      c = cyc;
      applyStimulus(1, 1'b0);
      expectEvent(c + LAT, EV_PRESS, 1);
      tick(LAT);
      checkOutput("level after bounce", key_level, 4'b0010);
      c = cyc;
      applyStimulus(1, 1'b1);
      expectEvent(c + LAT, EV_RELEASE, 1);
      tick(LAT + 2);

      // Long press and auto-repeat on key 2; release coincides with a repeat slot
      $display("[TB] long and repeat");
      c = cyc;
      p = c + LAT;
      applyStimulus(2, 1'b0);
      expectEvent(p, EV_PRESS, 2);
      expectEvent(p + LONG, EV_LONG, 2);
      for (int n = 1; n <= 6; n++) expectEvent(p + LONG + n * REP, EV_REPEAT, 2);
      tick(LAT + 100);
      applyStimulus(2, 1'b1);
      expectEvent(p + 100 + LAT, EV_RELEASE, 2);
      tick(LAT + 15);
      checkOutput("level after long", key_level, 4'b0000);

      // Short press on key 3
      $display("[TB] short press");
      c = cyc;
      applyStimulus(3, 1'b0);
      expectEvent(c + LAT, EV_PRESS, 3);
      tick(20);
      applyStimulus(3, 1'b1);
      expectEvent(c + 20 + LAT, EV_RELEASE, 3);
      tick(LAT + 40);

      // Release landing on the long-press edge suppresses key_long
      $display("[TB] release at long edge");
      c = cyc;
      p = c + LAT;
      applyStimulus(3, 1'b0);
      expectEvent(p, EV_PRESS, 3);
      tick(LAT + 30);
      applyStimulus(3, 1'b1);
      expectEvent(p + 30 + LAT, EV_RELEASE, 3);
      tick(LAT + 20);

      // Reset mid-hold on key 0
      $display("[TB] reset mid-hold");
      c = cyc;
      applyStimulus(0, 1'b0);
      expectEvent(c + LAT, EV_PRESS, 0);
      tick(LAT + 25);
      rst_n = 1'b0;
      #1;
      checkOutput("mid reset level", key_level,  '0);
      checkOutput("mid reset long",  key_long,   '0);
      tick(3);
      checkOutput("held reset level", key_level, '0);
      checkOutput("held reset press", key_press, '0);
      rst_n = 1'b1;
      d = cyc;
      expectEvent(d + LAT, EV_PRESS, 0);
      expectEvent(d + LAT + LONG, EV_LONG, 0);
      tick(LAT);
      checkOutput("press after reset", key_press, 4'b0001);
      tick(35);
      applyStimulus(0, 1'b1);
      expectEvent(d + 45 + LAT, EV_RELEASE, 0);
      tick(LAT + 5);

      // Concurrent presses on keys 0 and 3
      $display("[TB] concurrent keys");
      c = cyc;
      KEY = KEY & 4'b0110;
      expectEvent(c + LAT, EV_PRESS, 0);
      expectEvent(c + LAT, EV_PRESS, 3);
      tick(LAT);
      checkOutput("concurrent press", key_press, 4'b1001);
      c = cyc;
      KEY = '1;
      expectEvent(c + LAT, EV_RELEASE, 0);
      expectEvent(c + LAT, EV_RELEASE, 3);
      tick(LAT);
      checkOutput("concurrent release", key_release, 4'b1001);
      tick(3);

      foreach (expq[i]) begin
         assert_cnt++;
         fail_cnt++;
         $display("[TB] FAIL leftover %s key%0d: no pulse seen, required at cycle %0d",
                  kindName(int'(expq[i].kind)), expq[i].key, expq[i].cycle);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

endmodule
